// File: rtl/noc_input_port.sv
// ============================================================================
// Module   : noc_input_port
// Purpose  : NoC router input stage. Buffers incoming flits in a DEPTH-entry
//            FIFO, computes an XY route from each head flit, holds that route
//            for the whole packet (wormhole lock) and returns one credit per
//            flit it pops.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            data_i, valid_i    - incoming flit from upstream send_data
//            grant_i[4:0]       - one-hot grant from output-side arbitration
//            data_o             - flit at FIFO head (0 while empty)
//            req_o[4:0]         - one-hot route request (L,N,E,S,W)
//            port_en_o[4:0]     - one-hot forward strobe
//            credit_o           - one-cycle pulse per popped flit
//            error_o            - sticky protocol / overflow error
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module noc_input_port #(
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0,
  parameter int DEPTH = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  input  logic [4:0]  grant_i,
  output logic [15:0] data_o,
  output logic [4:0]  req_o,
  output logic [4:0]  port_en_o,
  output logic        credit_o,
  output logic        error_o
);

  localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [2:0]         c_X_ID     = 3'(X_ID);
  localparam logic [2:0]         c_Y_ID     = 3'(Y_ID);

  localparam logic [4:0] c_PORT_L = 5'b00001;
  localparam logic [4:0] c_PORT_N = 5'b00010;
  localparam logic [4:0] c_PORT_E = 5'b00100;
  localparam logic [4:0] c_PORT_S = 5'b01000;
  localparam logic [4:0] c_PORT_W = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [15:0]          r_mem [0:DEPTH-1];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [4:0]           r_route;
  logic                 r_error;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fwd;
  logic                 w_latch_route;
  logic                 w_err_proto;
  logic                 w_overflow;
  logic                 w_grant_hit;
  logic                 w_is_head;
  logic                 w_is_tail;
  logic [2:0]           w_dst_x;
  logic [2:0]           w_dst_y;
  logic [4:0]           w_route_nxt;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // FIFO status. A write into a full FIFO is still accepted when the head is
  // popped in the same cycle, so the slot frees up in time.
  // --------------------------------------------------------------------------
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_CNT_FULL);
  assign w_push     = valid_i & (~w_full | w_pop);
  assign w_overflow = valid_i & w_full & ~w_pop;

  // Head is gated while empty so stale storage never leaks out (and reset
  // shows 0 without having to clear the array).
  assign data_o    = w_empty ? 16'h0000 : r_mem[r_rd_ptr];

  // All decode below is only acted on while the FIFO is non-empty.
  assign w_is_head   = data_o[15];
  assign w_is_tail   = data_o[14];
  assign w_dst_x     = data_o[13:11];
  assign w_dst_y     = data_o[10:8];
  assign w_grant_hit = |(grant_i & r_route);

  // XY routing: resolve X first, then Y.
  always_comb begin
    w_route_nxt = c_PORT_L;
    if (w_dst_x > c_X_ID) begin
      w_route_nxt = c_PORT_E;
    end else if (w_dst_x < c_X_ID) begin
      w_route_nxt = c_PORT_W;
    end else if (w_dst_y > c_Y_ID) begin
      w_route_nxt = c_PORT_N;
    end else if (w_dst_y < c_Y_ID) begin
      w_route_nxt = c_PORT_S;
    end
  end

  // --------------------------------------------------------------------------
  // Packet FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_fwd         = 1'b0;
    w_latch_route = 1'b0;
    w_err_proto   = 1'b0;
    req_o         = 5'b00000;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_is_head) begin
            w_latch_route = 1'b1;
            w_state_nxt   = S_REQ;
          end else begin
            // Body flit with no open packet: discard it but still return
            // its credit so upstream does not lose a buffer slot.
            w_pop       = 1'b1;
            w_err_proto = 1'b1;
          end
        end
      end
      S_REQ: begin
        req_o = r_route;
        if (!w_empty && w_grant_hit) begin
          w_fwd       = 1'b1;
          w_pop       = 1'b1;
          w_state_nxt = w_is_tail ? S_IDLE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        req_o = r_route;
        if (!w_empty && w_grant_hit) begin
          w_fwd = 1'b1;
          w_pop = 1'b1;
          // A new head inside an open packet is a framing error; it is
          // still forwarded as a body flit to keep the worm intact.
          if (w_is_head) begin
            w_err_proto = 1'b1;
          end
          if (w_is_tail) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign port_en_o = w_fwd ? r_route : 5'b00000;
  assign credit_o  = w_pop;
  assign error_o   = r_error;

  // --------------------------------------------------------------------------
  // State, pointers, occupancy and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_route  <= 5'b00000;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_route) begin
        r_route <= w_route_nxt;
      end
      if (w_push) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_err_proto || w_overflow) begin
        r_error <= 1'b1;
      end
    end
  end

  // Flit storage needs no reset: contents are only visible through data_o,
  // which is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_input_port.sv
// ============================================================================
// Module   : tb_noc_input_port
// Purpose  : Self-checking bench for noc_input_port (X_ID=2, Y_ID=2, DEPTH=5).
//            Directed scenarios plus a randomized packet stream, all compared
//            cycle by cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_noc_input_port;

  localparam int DEPTH = 5;
  localparam int MX    = 2;
  localparam int MY    = 2;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_ACT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_i = 16'h0000;
  logic        valid_i = 1'b0;
  logic [4:0]  grant_i = 5'b00000;
  logic [15:0] data_o;
  logic [4:0]  req_o;
  logic [4:0]  port_en_o;
  logic        credit_o;
  logic        error_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_input_port #(.X_ID(MX), .Y_ID(MY), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .grant_i   (grant_i),
    .data_o    (data_o),
    .req_o     (req_o),
    .port_en_o (port_en_o),
    .credit_o  (credit_o),
    .error_o   (error_o)
  );

  // --------------------------------------------------------------------------
  // Reference model: a queue of buffered flits, the packet phase and the
  // route chosen for the open packet.
  // --------------------------------------------------------------------------
  logic [15:0] mq[$];
  int          ph;
  logic [4:0]  mroute;
  logic        merr;
  bit          m_v, m_fwd, m_pop;
  logic [15:0] m_d;

  logic [4:0]  e_req, e_pen;
  logic        e_cred, e_err, e_ne;
  logic [15:0] e_data;

  function automatic logic [4:0] xy(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[13:11]);
    dy = int'(f[10:8]);
    if (dx > MX) return 5'b00100;
    if (dx < MX) return 5'b10000;
    if (dy > MY) return 5'b00010;
    if (dy < MY) return 5'b01000;
    return 5'b00001;
  endfunction

  task automatic model_reset();
    mq.delete();
    ph     = P_IDLE;
    mroute = 5'b00000;
    merr   = 1'b0;
  endtask

  // Expected outputs for the current inputs (before the coming clock edge).
  task automatic model_eval();
    m_v   = valid_i;
    m_d   = data_i;
    e_ne  = (mq.size() > 0);
    m_fwd = (ph != P_IDLE) && e_ne && ((grant_i & mroute) != 5'b00000);
    m_pop = m_fwd;
    if (ph == P_IDLE && e_ne) begin
      if (!mq[0][15]) m_pop = 1'b1;
    end
    e_req  = (ph == P_IDLE) ? 5'b00000 : mroute;
    e_pen  = m_fwd ? mroute : 5'b00000;
    e_cred = m_pop;
    e_err  = merr;
    e_data = e_ne ? mq[0] : 16'h0000;
  endtask

  // State update at the clock edge using the inputs captured by model_eval.
  task automatic model_commit();
    bit          full;
    logic [15:0] f;
    full = (mq.size() == DEPTH);
    if (ph == P_IDLE) begin
      if (mq.size() > 0) begin
        if (mq[0][15]) begin
          mroute = xy(mq[0]);
          ph     = P_REQ;
        end else begin
          f    = mq.pop_front();
          merr = 1'b1;
        end
      end
    end else if (m_fwd) begin
      f = mq.pop_front();
      if (ph == P_ACT && f[15]) merr = 1'b1;
      ph = f[14] ? P_IDLE : P_ACT;
    end
    if (m_v) begin
      if (!full || m_pop) mq.push_back(m_d);
      else                merr = 1'b1;
    end
  endtask

  // Reset helper (no checks); leaves the bench 1 ns after a rising edge.
  task automatic do_reset();
    valid_i = 1'b0;
    grant_i = 5'b00000;
    data_i  = 16'h0000;
    rst_n   = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    valid_i = 1'b0;
    grant_i = 5'b00000;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({data_o, req_o, port_en_o, credit_o, error_o} !== 28'h0) begin
      failures++;
      $display("FAIL reset_held outs got=%h exp=0", {data_o, req_o, port_en_o, credit_o, error_o});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({data_o, req_o, port_en_o, credit_o, error_o} !== 28'h0) begin
      failures++;
      $display("FAIL reset_released outs got=%h exp=0", {data_o, req_o, port_en_o, credit_o, error_o});
    end
  endtask

  task automatic test_route_east();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      valid_i = (c == 0);
      data_i  = 16'hDAAA;
      grant_i = 5'b00100;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL east c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (c == 2) begin
        checks++;
        if ({req_o, port_en_o, credit_o, data_o} !== {5'b00100, 5'b00100, 1'b1, 16'hDAAA}) begin
          failures++;
          $display("FAIL east_cycle2 req/pen/cred/data got=%h exp=%h",
                   {req_o, port_en_o, credit_o, data_o}, {5'b00100, 5'b00100, 1'b1, 16'hDAAA});
        end
      end
      @(posedge clk);
      #1;
      model_commit();
    end
  endtask

  task automatic test_local();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      valid_i = (c == 0);
      data_i  = 16'hD255;
      grant_i = (c < 5) ? 5'b00010 : 5'b00001;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL local c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (c == 3) begin
        checks++;
        if ({req_o, port_en_o} !== {5'b00001, 5'b00000}) begin
          failures++;
          $display("FAIL local_wrong_grant req/pen got=%b exp=%b", {req_o, port_en_o}, {5'b00001, 5'b00000});
        end
      end
      if (c == 5) begin
        checks++;
        if ({port_en_o, data_o} !== {5'b00001, 16'hD255}) begin
          failures++;
          $display("FAIL local_fwd pen/data got=%h exp=%h", {port_en_o, data_o}, {5'b00001, 16'hD255});
        end
      end
      @(posedge clk);
      #1;
      model_commit();
    end
  endtask

  task automatic test_wormhole();
    logic [15:0] pkt [4];
    int          npen, ncred, first, last;
    pkt[0] = 16'h9A01; pkt[1] = 16'h0002; pkt[2] = 16'h0003; pkt[3] = 16'h4004;
    npen = 0; ncred = 0; first = -1; last = -1;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      valid_i = (c < 4);
      data_i  = (c < 4) ? pkt[c] : 16'h0000;
      grant_i = 5'b00100;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL worm c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (port_en_o == 5'b00100) begin
        checks++;
        if (npen > 3 || data_o !== pkt[npen > 3 ? 3 : npen]) begin
          failures++;
          $display("FAIL worm_data idx%0d got=%h exp=%h", npen, data_o, pkt[npen > 3 ? 3 : npen]);
        end
        if (first < 0) first = c;
        last = c;
        npen++;
      end
      if (credit_o === 1'b1) ncred++;
      @(posedge clk);
      #1;
      model_commit();
    end
    checks++;
    if (npen != 4 || ncred != 4 || (last - first) != 3 || req_o !== 5'b00000) begin
      failures++;
      $display("FAIL worm_summary pen=%0d cred=%0d span=%0d req=%b exp pen=4 cred=4 span=3 req=0",
               npen, ncred, last - first, req_o);
    end
  endtask

  task automatic test_full();
    int ncred, nfwd;
    // Part 1: sixth write with no pop is lost
    do_reset();
    ncred = 0; nfwd = 0;
    for (int c = 0; c < 18; c++) begin
      valid_i = (c < 6);
      data_i  = (c == 0) ? 16'h9A01 : ((c == 4) ? 16'h4004 : 16'(c));
      grant_i = (c < 7) ? 5'b00000 : 5'b00100;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL full c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (c < 7 && credit_o === 1'b1) ncred++;
      if (port_en_o != 5'b00000) nfwd++;
      if (c == 6) begin
        checks++;
        if (error_o !== 1'b1) begin
          failures++;
          $display("FAIL full_overflow_err got=%b exp=1", error_o);
        end
      end
      @(posedge clk);
      #1;
      model_commit();
    end
    checks++;
    if (ncred != 0 || nfwd != 5) begin
      failures++;
      $display("FAIL full_counts credits_while_blocked=%0d fwd=%0d exp 0 and 5", ncred, nfwd);
    end
    // Part 2: sixth write coincides with a pop and is accepted
    do_reset();
    nfwd = 0;
    for (int c = 0; c < 16; c++) begin
      valid_i = (c < 6);
      data_i  = (c == 0) ? 16'h9A01 : ((c == 5) ? 16'h4006 : 16'(c));
      grant_i = (c < 5) ? 5'b00000 : 5'b00100;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL fullpop c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (port_en_o != 5'b00000) nfwd++;
      @(posedge clk);
      #1;
      model_commit();
    end
    checks++;
    if (nfwd != 6 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_summary fwd=%0d err=%b exp fwd=6 err=0", nfwd, error_o);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      valid_i = (c == 0);
      data_i  = 16'h0123;
      grant_i = 5'b11111;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL orphan c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (c == 1) begin
        checks++;
        if ({req_o, port_en_o, credit_o} !== {5'b00000, 5'b00000, 1'b1}) begin
          failures++;
          $display("FAIL orphan_pop req/pen/cred got=%b exp=%b", {req_o, port_en_o, credit_o}, 11'b1);
        end
      end
      if (c == 2) begin
        checks++;
        if ({req_o, error_o} !== {5'b00000, 1'b1}) begin
          failures++;
          $display("FAIL orphan_err req/err got=%b exp=%b", {req_o, error_o}, 6'b000001);
        end
      end
      @(posedge clk);
      #1;
      model_commit();
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] pkt [4];
    pkt[0] = 16'h9A01; pkt[1] = 16'h0011; pkt[2] = 16'h0012; pkt[3] = 16'h0013;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      valid_i = 1'b1;
      data_i  = pkt[c];
      grant_i = (c == 2) ? 5'b00100 : 5'b00000;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL rstmid c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      @(posedge clk);
      #1;
      model_commit();
    end
    // Open packet with three bodies buffered and no grant
    valid_i = 1'b0;
    grant_i = 5'b00000;
    @(negedge clk);
    checks++;
    if ({req_o, data_o} !== {5'b00100, 16'h0011}) begin
      failures++;
      $display("FAIL rstmid_active req/data got=%h exp=%h", {req_o, data_o}, {5'b00100, 16'h0011});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_o, req_o, port_en_o, credit_o, error_o} !== 28'h0) begin
      failures++;
      $display("FAIL rstmid_async outs got=%h exp=0", {data_o, req_o, port_en_o, credit_o, error_o});
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // After release nothing may emerge; then a fresh packet routes normally
    for (int c = 0; c < 9; c++) begin
      valid_i = (c == 4);
      data_i  = 16'hDAAA;
      grant_i = 5'b00100;
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL rstmid_after c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      @(posedge clk);
      #1;
      model_commit();
    end
  endtask

  task automatic test_random();
    bit          in_pkt;
    logic [15:0] f;
    bit          tail;
    do_reset();
    in_pkt = 1'b0;
    for (int c = 0; c < 600; c++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      f = 16'($urandom);
      if (valid_i) begin
        tail = ($urandom_range(0, 3) == 0);
        f[15] = !in_pkt;
        f[14] = tail;
        if ($urandom_range(0, 49) == 0) f[15] = ~f[15];
        in_pkt = !tail;
      end
      data_i = f;
      case ($urandom_range(0, 9))
        0, 1, 2: grant_i = 5'b00000;
        3:       grant_i = 5'($urandom);
        default: grant_i = 5'b00001 << $urandom_range(0, 4);
      endcase
      model_eval();
      @(negedge clk);
      checks++;
      if ({req_o, port_en_o, credit_o, error_o} !== {e_req, e_pen, e_cred, e_err}) begin
        failures++;
        $display("FAIL rand c%0d req/pen/cred/err got=%b exp=%b", c,
                 {req_o, port_en_o, credit_o, error_o}, {e_req, e_pen, e_cred, e_err});
      end
      if (e_ne) begin
        checks++;
        if (data_o !== e_data) begin
          failures++;
          $display("FAIL rand_data c%0d got=%h exp=%h", c, data_o, e_data);
        end
      end
      @(posedge clk);
      #1;
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_route_east();
    test_local();
    test_wormhole();
    test_full();
    test_orphan();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
